fetch_stage: RTL and testbench

Instruction-fetch (IF) stage of the 5-stage RV32I pipeline, directly upstream of decode. It owns the program counter, drives the instruction-memory address, captures returned words into a small fetch queue, and presents {pc, instruction} pairs to decode over a valid/ready handshake. Redirects from the branch/jump resolution logic flush the queue and restart fetch at the new target.

---
 rtl/core_pkg.sv | 18 +
 rtl/fetch_stage_if.sv | 18 +
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_stage.sv | 89 ++++++++
 tb/tb_fetch_stage.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Types and constants shared by the RV32I front end.
//   fetch_entry_t    : one fetch-queue slot {pc, instr}
//   INSTR_BYTES      : PC increment for one sequential instruction
//   DEFAULT_RESET_PC : default reset vector
// ---------------------------------------------------------------------------
package core_pkg;

    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Fetch -> decode handshake.
//   id_valid : head entry is valid          (fetch -> decode)
//   id_ready : decode accepts the head      (decode -> fetch)
//   id_instr : head instruction word        (fetch -> decode)
//   id_pc    : PC of the head instruction   (fetch -> decode)
// Modports: master = fetch side, slave = decode side.
// ---------------------------------------------------------------------------
interface fetch_stage_if;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    modport master (output id_valid, output id_instr, output id_pc, input id_ready);
    modport slave  (input id_valid, input id_instr, input id_pc, output id_ready);
endinterface

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small circular queue of fetch_entry_t. DEPTH need not be a power of two;
// pointers wrap explicitly after DEPTH-1.
//   clk, reset : clock, async active-high reset (clears contents too)
//   push       : write push_data at the tail
//   pop        : drop the head entry (caller guarantees non-empty)
//   flush      : empty the queue; overrides push and pop
//   head       : registered head entry (stale data when empty)
//   count      : occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_fifo
    import core_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            // Contents are left in place; only occupancy and pointers reset.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// RV32I instruction-fetch stage: owns the PC, drives the instruction-memory
// address, queues {pc, instr} pairs and hands them to decode.
//   clk, reset     : clock, async active-high reset
//   iaddr          : instruction-memory address (= current pc)
//   idata          : instruction word, combinational response to iaddr
//   redirect_valid : flush queue and restart fetch at redirect_pc
//   redirect_pc    : redirect target
//   id             : fetch_stage_if.master handshake to decode
//   fq_count       : fetch-queue occupancy
//   fetch_misalign : sticky misaligned-redirect flag (only with the
//                    FETCH_STAGE_MISALIGN_CHECK_EN macro defined)
// Without FETCH_STAGE_MISALIGN_CHECK_EN the low two bits of a redirect
// target are dropped when loaded into pc.
// ---------------------------------------------------------------------------
module fetch_stage
    import core_pkg::*;
#(
    parameter  logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter  int          FQ_DEPTH = 2,
    localparam int          CW       = $clog2(FQ_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [31:0]   iaddr,
    input  logic [31:0]   idata,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    fetch_stage_if.master id,
`ifdef FETCH_STAGE_MISALIGN_CHECK_EN
    output logic          fetch_misalign,
`endif
    output logic [CW-1:0] fq_count
);

    logic [31:0]  pc;
    logic [31:0]  redirect_tgt;
    logic         fetch_blocked;
    logic         push;
    logic         pop;
    logic         full;
    fetch_entry_t head;

`ifdef FETCH_STAGE_MISALIGN_CHECK_EN
    logic misalign_q;

    // Sticky until reset or a redirect to an aligned target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               misalign_q <= 1'b0;
        else if (redirect_valid) misalign_q <= |redirect_pc[1:0];
    end

    assign fetch_misalign = misalign_q;
    assign redirect_tgt   = redirect_pc;
    assign fetch_blocked  = misalign_q;
`else
    assign redirect_tgt   = redirect_pc & 32'hFFFF_FFFC;
    assign fetch_blocked  = 1'b0;
`endif

    assign iaddr       = pc;
    assign id.id_valid = (fq_count != '0);
    assign id.id_instr = head.instr;
    assign id.id_pc    = head.pc;

    assign pop  = id.id_valid && id.id_ready;
    assign full = (fq_count == CW'(FQ_DEPTH));
    // A full queue still accepts a fetch when decode drains the head.
    assign push = !redirect_valid && !fetch_blocked && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)               pc <= RESET_PC;
        else if (redirect_valid) pc <= redirect_tgt;
        else if (push)           pc <= pc + INSTR_BYTES;   // wraps mod 2^32
    end

    fetch_fifo #(.DEPTH(FQ_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ('{pc: pc, instr: idata}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (fq_count)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage (FQ_DEPTH = 2, RESET_PC = 0). The imem
// model returns idata = iaddr ^ 32'hA5A5_0000. Define
// FETCH_STAGE_MISALIGN_CHECK_EN for the misalign-check build.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  fq_count;
`ifdef FETCH_STAGE_MISALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    int checks = 0;
    int errors = 0;

    fetch_stage_if id_if ();

    fetch_stage #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .iaddr          (iaddr),
        .idata          (idata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id             (id_if),
`ifdef FETCH_STAGE_MISALIGN_CHECK_EN
        .fetch_misalign (fetch_misalign),
`endif
        .fq_count       (fq_count)
    );

    assign idata = iaddr ^ 32'hA5A5_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Head, occupancy and fetch address in one go.
    task automatic chk_state(input string tag, input logic v, input logic [31:0] pc_e,
                             input logic [31:0] ia_e, input logic [1:0] cnt_e);
        chk({tag, ".valid"}, 32'(id_if.id_valid), 32'(v));
        if (v) begin
            chk({tag, ".pc"},    id_if.id_pc,    pc_e);
            chk({tag, ".instr"}, id_if.id_instr, pc_e ^ 32'hA5A5_0000);
        end
        chk({tag, ".iaddr"}, iaddr, ia_e);
        chk({tag, ".count"}, 32'(fq_count), 32'(cnt_e));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_if.id_ready = 1'b1;

        // Reset values
        #2;
        chk("rst.valid", 32'(id_if.id_valid), 32'h0);
        chk("rst.instr", id_if.id_instr, 32'h0);
        chk("rst.pc",    id_if.id_pc,    32'h0);
        chk("rst.iaddr", iaddr,          32'h0);
        chk("rst.count", 32'(fq_count),  32'h0);
        #1 reset = 1'b0;

        // Streaming at one instruction per cycle
        step(); chk_state("s1", 1'b1, 32'h0, 32'h4,  2'd1);
        step(); chk_state("s2", 1'b1, 32'h4, 32'h8,  2'd1);
        step(); chk_state("s3", 1'b1, 32'h8, 32'hC,  2'd1);
        step(); chk_state("s4", 1'b1, 32'hC, 32'h10, 2'd1);

        // Fill to full, then asynchronous reset between edges
        id_if.id_ready = 1'b0;
        step(); chk_state("fill", 1'b1, 32'hC, 32'h14, 2'd2);
        #3 reset = 1'b1;
        #1;
        chk("arst.valid", 32'(id_if.id_valid), 32'h0);
        chk("arst.count", 32'(fq_count),       32'h0);
        chk("arst.pc",    id_if.id_pc,         32'h0);
        chk("arst.instr", id_if.id_instr,      32'h0);
        chk("arst.iaddr", iaddr,               32'h0);
        #1 reset = 1'b0;

        // Decode stall: queue saturates at 2, pc holds at 8
        step(); chk_state("st1", 1'b1, 32'h0, 32'h4, 2'd1);
        step(); chk_state("st2", 1'b1, 32'h0, 32'h8, 2'd2);
        step(); chk_state("st3", 1'b1, 32'h0, 32'h8, 2'd2);
        step(); chk_state("st4", 1'b1, 32'h0, 32'h8, 2'd2);
        step(); chk_state("st5", 1'b1, 32'h0, 32'h8, 2'd2);
        step(); chk_state("st6", 1'b1, 32'h0, 32'h8, 2'd2);

        // Resume: full queue with pop pushes too, nothing lost or duplicated
        id_if.id_ready = 1'b1;
        step(); chk_state("rs1", 1'b1, 32'h4, 32'hC,  2'd2);
        step(); chk_state("rs2", 1'b1, 32'h8, 32'h10, 2'd2);
        step(); chk_state("rs3", 1'b1, 32'hC, 32'h14, 2'd2);

        // Redirect while full and popping
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step(); chk_state("rd1", 1'b0, 32'h0, 32'h100, 2'd0);
        redirect_valid = 1'b0;
        step(); chk_state("rd2", 1'b1, 32'h100, 32'h104, 2'd1);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step(); chk_state("wr1", 1'b0, 32'h0, 32'hFFFF_FFFC, 2'd0);
        redirect_valid = 1'b0;
        step(); chk_state("wr2", 1'b1, 32'hFFFF_FFFC, 32'h0, 2'd1);
        step(); chk_state("wr3", 1'b1, 32'h0,         32'h4, 2'd1);

        // Misaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
`ifdef FETCH_STAGE_MISALIGN_CHECK_EN
        step(); chk_state("ma1", 1'b0, 32'h0, 32'h102, 2'd0);
        chk("ma1.flag", 32'(fetch_misalign), 32'h1);
        redirect_valid = 1'b0;
        step(); chk_state("ma2", 1'b0, 32'h0, 32'h102, 2'd0);
        chk("ma2.flag", 32'(fetch_misalign), 32'h1);
        step(); chk_state("ma3", 1'b0, 32'h0, 32'h102, 2'd0);
`else
        step(); chk_state("ma1", 1'b0, 32'h0,   32'h100, 2'd0);
        redirect_valid = 1'b0;
        step(); chk_state("ma2", 1'b1, 32'h100, 32'h104, 2'd1);
`endif

        // Aligned redirect restarts fetch
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step(); chk_state("al1", 1'b0, 32'h0, 32'h200, 2'd0);
`ifdef FETCH_STAGE_MISALIGN_CHECK_EN
        chk("al1.flag", 32'(fetch_misalign), 32'h0);
`endif
        redirect_valid = 1'b0;
        step(); chk_state("al2", 1'b1, 32'h200, 32'h204, 2'd1);
        step(); chk_state("al3", 1'b1, 32'h204, 32'h208, 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
